// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing for the glyph-mode VGA top.
// Produces the pixel/line counters, syncs, display enable and line/frame strobes.
// It also produces glyph-cell coordinates (vpos / GLYPH_H, vpos % GLYPH_H) and a
// frame counter that runs on the pixel clock. Every output is registered and
// describes the pixel at the current hpos/vpos.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int GLYPH_H   = 12,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_run,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [5:0] cell_row,
  output logic [3:0] cell_line,
  output logic [9:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VISIBLE = 10'(H_DISPLAY);
  localparam logic [9:0] V_VISIBLE = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [3:0] CELL_LAST = 4'(GLYPH_H - 1);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       display_on_q, display_on_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [5:0] cell_row_q, cell_row_d;
  logic [3:0] cell_line_q, cell_line_d;
  logic [9:0] frame_count_q, frame_count_d;
  logic       armed_q, armed_d;
  logic       h_wrap;
  logic       v_wrap;

  // Next raster position, with the glyph-cell counters stepping alongside vpos (no divider)
  always_comb begin
    h_wrap      = (hpos_q == H_LAST);
    v_wrap      = (vpos_q == V_LAST);
    hpos_d      = h_wrap ? 10'd0 : hpos_q + 10'd1;
    vpos_d      = vpos_q;
    cell_row_d  = cell_row_q;
    cell_line_d = cell_line_q;
    if (h_wrap) begin
      if (v_wrap) begin
        vpos_d      = 10'd0;
        cell_row_d  = 6'd0;
        cell_line_d = 4'd0;
      end else begin
        vpos_d = vpos_q + 10'd1;
        if (cell_line_q == CELL_LAST) begin
          cell_line_d = 4'd0;
          cell_row_d  = cell_row_q + 6'd1;
        end else begin
          cell_line_d = cell_line_q + 4'd1;
        end
      end
    end
  end

  // Decode syncs/enable/strobes from the upcoming position so they register in step with it
  always_comb begin
    hsync_d       = (hpos_d >= HS_FIRST && hpos_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (vpos_d >= VS_FIRST && vpos_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
    display_on_d  = (hpos_d < H_VISIBLE) && (vpos_d < V_VISIBLE);
    line_start_d  = (hpos_d == 10'd0);
    frame_start_d = (hpos_d == 10'd0) && (vpos_d == 10'd0);
    // The wrap taken on the reset-release edge is not a completed frame, hence the armed gate
    frame_count_d = frame_count_q;
    if (h_wrap && v_wrap && armed_q && frame_run) begin
      frame_count_d = frame_count_q + 10'd1;
    end
    armed_d = 1'b1;
  end

  // State registers; reset parks the raster on the last pixel so release lands on (0,0)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      cell_row_q    <= 6'd0;
      cell_line_q   <= 4'd0;
      frame_count_q <= 10'd0;
      armed_q       <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      cell_row_q    <= cell_row_d;
      cell_line_q   <= cell_line_d;
      frame_count_q <= frame_count_d;
      armed_q       <= armed_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign cell_row    = cell_row_q;
  assign cell_line   = cell_line_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three instances share one clock.
//   inst0 = full 640x480 timing (reset, line timing, mid-line reset)
//   inst1 = short lines, full 525-line frame (cell counters, frame timing, hold, mid-frame reset)
//   inst2 = tiny raster, active-high syncs (frame_count 1023 -> 0 wrap)
// A cycle-index model (position = elapsed cycles mod line/frame length) checks every output each cycle.
module tb_vga_timing_gen;

  localparam int NI = 3;
  localparam int HD [NI] = '{640, 8, 2};
  localparam int HF [NI] = '{16, 1, 1};
  localparam int HS [NI] = '{96, 2, 1};
  localparam int HB [NI] = '{48, 1, 1};
  localparam int VD [NI] = '{480, 480, 3};
  localparam int VF [NI] = '{10, 10, 1};
  localparam int VS [NI] = '{2, 2, 1};
  localparam int VB [NI] = '{33, 33, 1};
  localparam int GH [NI] = '{12, 12, 2};
  localparam bit SP [NI] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v  [NI];
  logic       run_v  [NI];
  logic [9:0] hpos_w [NI];
  logic [9:0] vpos_w [NI];
  logic       hs_w   [NI];
  logic       vs_w   [NI];
  logic       de_w   [NI];
  logic       ls_w   [NI];
  logic       fs_w   [NI];
  logic [5:0] row_w  [NI];
  logic [3:0] line_w [NI];
  logic [9:0] fc_w   [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      vga_timing_gen #(
        .H_DISPLAY(HD[gi]), .H_FRONT(HF[gi]), .H_SYNC(HS[gi]), .H_BACK(HB[gi]),
        .V_DISPLAY(VD[gi]), .V_FRONT(VF[gi]), .V_SYNC(VS[gi]), .V_BACK(VB[gi]),
        .GLYPH_H(GH[gi]), .SYNC_POL(SP[gi])
      ) u_dut (
        .clk(clk), .rst_n(rst_v[gi]), .frame_run(run_v[gi]),
        .hpos(hpos_w[gi]), .vpos(vpos_w[gi]), .hsync(hs_w[gi]), .vsync(vs_w[gi]),
        .display_on(de_w[gi]), .line_start(ls_w[gi]), .frame_start(fs_w[gi]),
        .cell_row(row_w[gi]), .cell_line(line_w[gi]), .frame_count(fc_w[gi])
      );
    end
  endgenerate

  typedef struct {
    int h; int v; int hs; int vs; int de; int ls; int fs; int row; int line;
  } exp_t;

  typedef struct {
    int vpos; int row; int line;
  } cell_vec_t;

  cell_vec_t  cell_tbl [6];
  int         cell_hit [6];

  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         phase = 0;
  int         t_m  [NI] = '{-2, -2, -2};   // cycles since reset release; -1 in reset, -2 never reset
  int         fc_m [NI] = '{0, 0, 0};
  int         full_hs_cnt = 0;
  int         full_de_fall = -1;
  int         full_ls_cyc = -1;
  int         full_line_done = 0;
  int         main_fs_n = 0;
  int         main_fs_cyc = -1;
  int         wrap_seen = 0;
  logic [9:0] prev_fc2 = 10'd0;

  function automatic int htot(int k);
    return HD[k] + HF[k] + HS[k] + HB[k];
  endfunction

  function automatic int flen(int k);
    return htot(k) * (VD[k] + VF[k] + VS[k] + VB[k]);
  endfunction

  // Expected outputs straight from the raster rules, given cycles since release
  function automatic exp_t model(int k, int t);
    exp_t e;
    int   ht  = htot(k);
    int   vt  = VD[k] + VF[k] + VS[k] + VB[k];
    int   pol = int'(SP[k]);
    int   pix;
    if (t < 0) begin
      e.h = ht - 1; e.v = vt - 1; e.hs = 1 - pol; e.vs = 1 - pol;
      e.de = 0; e.ls = 0; e.fs = 0; e.row = 0; e.line = 0;
    end else begin
      pix    = t % (ht * vt);
      e.h    = pix % ht;
      e.v    = pix / ht;
      e.hs   = (e.h >= HD[k] + HF[k] && e.h < HD[k] + HF[k] + HS[k]) ? pol : 1 - pol;
      e.vs   = (e.v >= VD[k] + VF[k] && e.v < VD[k] + VF[k] + VS[k]) ? pol : 1 - pol;
      e.de   = (e.h < HD[k] && e.v < VD[k]) ? 1 : 0;
      e.ls   = (e.h == 0) ? 1 : 0;
      e.fs   = (pix == 0) ? 1 : 0;
      e.row  = e.v / GH[k];
      e.line = e.v % GH[k];
    end
    return e;
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s inst%0d cyc=%0d: got %0d, expected %0d", name, k, cyc, act, exp);
    end
  endtask

  task automatic observe();
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      if (t_m[k] < -1) continue;
      e = model(k, t_m[k]);
      chk("hpos", k, 32'(hpos_w[k]), e.h);
      chk("vpos", k, 32'(vpos_w[k]), e.v);
      chk("hsync", k, 32'(hs_w[k]), e.hs);
      chk("vsync", k, 32'(vs_w[k]), e.vs);
      chk("display_on", k, 32'(de_w[k]), e.de);
      chk("line_start", k, 32'(ls_w[k]), e.ls);
      chk("frame_start", k, 32'(fs_w[k]), e.fs);
      chk("cell_row", k, 32'(row_w[k]), e.row);
      chk("cell_line", k, 32'(line_w[k]), e.line);
      chk("frame_count", k, 32'(fc_w[k]), fc_m[k]);
    end
    // Cell-counter corner vectors on inst1, checked at the start of each listed line
    if (t_m[1] >= 0) begin
      e = model(1, t_m[1]);
      if (e.h == 0) begin
        for (int i = 0; i < 6; i++) begin
          if (e.v == cell_tbl[i].vpos) begin
            chk("tbl_row", 1, 32'(row_w[1]), cell_tbl[i].row);
            chk("tbl_line", 1, 32'(line_w[1]), cell_tbl[i].line);
            if (cell_hit[i] == 0)
              $display("vec vpos=%0d: row=%0d line=%0d (want %0d/%0d)", cell_tbl[i].vpos,
                       row_w[1], line_w[1], cell_tbl[i].row, cell_tbl[i].line);
            cell_hit[i] = 1;
          end
        end
      end
    end
    // First full line of inst0: hsync width, enable fall point, line_start period
    if (t_m[0] >= 0 && full_line_done == 0) begin
      if (hs_w[0] == 1'b0) full_hs_cnt++;
      if (de_w[0] == 1'b0 && full_de_fall < 0) full_de_fall = int'(hpos_w[0]);
      if (ls_w[0]) begin
        if (full_ls_cyc >= 0) begin
          chk("line_period", 0, cyc - full_ls_cyc, 800);
          chk("hsync_width", 0, full_hs_cnt, 96);
          chk("de_fall_hpos", 0, full_de_fall, 640);
          full_line_done = 1;
          $display("line: period=%0d hsync_clks=%0d de_fall=%0d", cyc - full_ls_cyc,
                   full_hs_cnt, full_de_fall);
        end
        full_ls_cyc = cyc;
      end
    end
    // inst1 frame starts: period and frame_count at each new frame while running
    if (t_m[1] < 0) begin
      main_fs_n   = 0;
      main_fs_cyc = -1;
    end else if (fs_w[1]) begin
      main_fs_n++;
      if (phase == 1 && main_fs_n >= 2) begin
        chk("frame_period", 1, cyc - main_fs_cyc, 6300);
        chk("fc_at_fs", 1, 32'(fc_w[1]), main_fs_n - 1);
        $display("frame_start #%0d: period=%0d frame_count=%0d", main_fs_n,
                 cyc - main_fs_cyc, fc_w[1]);
      end
      main_fs_cyc = cyc;
    end
    // inst2 frame_count wrap 1023 -> 0
    if (t_m[2] >= 0) begin
      if (fs_w[2] && prev_fc2 == 10'd1023) begin
        chk("fc_wrap", 2, 32'(fc_w[2]), 0);
        if (wrap_seen == 0) $display("wrap: frame_count 1023 -> %0d", fc_w[2]);
        wrap_seen = 1;
      end
      prev_fc2 = fc_w[2];
    end
  endtask

  task automatic tick();
    logic r  [NI];
    logic rn [NI];
    for (int k = 0; k < NI; k++) begin
      r[k]  = rst_v[k];
      rn[k] = run_v[k];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (!r[k]) begin
        t_m[k]  = -1;
        fc_m[k] = 0;
      end else if (t_m[k] >= -1) begin
        t_m[k]++;
        if (t_m[k] > 0 && (t_m[k] % flen(k)) == 0 && rn[k]) fc_m[k] = (fc_m[k] + 1) % 1024;
      end
    end
    observe();
  endtask

  // Advance until the model position of inst k reaches (h, v); v < 0 means any line
  task automatic wait_pos(int k, int h, int v, int limit, string name);
    exp_t e;
    int   n = 0;
    e = model(k, t_m[k]);
    while (!(e.h == h && (v < 0 || e.v == v)) && n < limit) begin
      tick();
      n++;
      e = model(k, t_m[k]);
    end
    n_cmp++;
    if (!(e.h == h && (v < 0 || e.v == v))) begin
      n_fail++;
      $display("FAIL %s inst%0d: position (%0d,%0d) not reached in %0d cycles", name, k, h, v, limit);
    end
  endtask

  task automatic wait_main_fs(int target, int limit, string name);
    int n = 0;
    while (main_fs_n < target && n < limit) begin
      tick();
      n++;
    end
    n_cmp++;
    if (main_fs_n < target) begin
      n_fail++;
      $display("FAIL %s: frame_start #%0d not seen in %0d cycles", name, target, limit);
    end
  endtask

  initial begin
    cell_tbl[0] = '{vpos: 11,  row: 0,  line: 11};
    cell_tbl[1] = '{vpos: 12,  row: 1,  line: 0};
    cell_tbl[2] = '{vpos: 200, row: 16, line: 8};
    cell_tbl[3] = '{vpos: 479, row: 39, line: 11};
    cell_tbl[4] = '{vpos: 524, row: 43, line: 8};
    cell_tbl[5] = '{vpos: 0,   row: 0,  line: 0};
    for (int i = 0; i < 6; i++) cell_hit[i] = 0;

    // Reset for 3 clocks, then release
    for (int k = 0; k < NI; k++) begin
      rst_v[k] = 1'b0;
      run_v[k] = 1'b1;
    end
    repeat (3) tick();
    chk("rst_display_on", 0, 32'(de_w[0]), 0);
    chk("rst_hsync", 0, 32'(hs_w[0]), 1);
    chk("rst_vsync", 0, 32'(vs_w[0]), 1);
    chk("rst_hsync_pos", 2, 32'(hs_w[2]), 0);
    chk("rst_hpos", 0, 32'(hpos_w[0]), 799);
    $display("reset: hpos=%0d vpos=%0d de=%0d hs=%0d vs=%0d", hpos_w[0], vpos_w[0],
             de_w[0], hs_w[0], vs_w[0]);
    for (int k = 0; k < NI; k++) rst_v[k] = 1'b1;
    phase = 1;
    tick();
    chk("rel_hpos", 0, 32'(hpos_w[0]), 0);
    chk("rel_vpos", 0, 32'(vpos_w[0]), 0);
    chk("rel_frame_start", 0, 32'(fs_w[0]), 1);
    chk("rel_display_on", 0, 32'(de_w[0]), 1);
    chk("rel_frame_count", 0, 32'(fc_w[0]), 0);
    $display("release: hpos=%0d vpos=%0d fs=%0d de=%0d fc=%0d", hpos_w[0], vpos_w[0],
             fs_w[0], de_w[0], fc_w[0]);

    // Two full frames of inst1 with frame_run=1
    wait_main_fs(3, 13000, "run_frames");

    // Hold across three frame ends
    phase = 2;
    run_v[1] = 1'b0;
    repeat (3 * 6300) tick();
    chk("hold_fc", 1, 32'(fc_w[1]), 2);
    $display("hold: frame_count=%0d after 3 frame ends", fc_w[1]);

    // Random frame_run toggling; timing must be unaffected
    phase = 3;
    repeat (6300) begin
      run_v[0] = 1'($urandom_range(0, 1));
      run_v[1] = 1'($urandom_range(0, 1));
      tick();
    end
    run_v[0] = 1'b1;
    run_v[1] = 1'b1;
    $display("random frame_run: inst1 frame_count=%0d", fc_w[1]);

    // Mid-frame reset on inst1 at (5,200)
    phase = 4;
    wait_pos(1, 5, 200, 6300, "reach_5_200");
    rst_v[1] = 1'b0;
    tick();
    chk("mid_rst_hpos", 1, 32'(hpos_w[1]), 11);
    chk("mid_rst_vpos", 1, 32'(vpos_w[1]), 524);
    chk("mid_rst_row", 1, 32'(row_w[1]), 0);
    chk("mid_rst_fc", 1, 32'(fc_w[1]), 0);
    rst_v[1] = 1'b1;
    tick();
    chk("mid_rel_hpos", 1, 32'(hpos_w[1]), 0);
    chk("mid_rel_vpos", 1, 32'(vpos_w[1]), 0);
    chk("mid_rel_fc", 1, 32'(fc_w[1]), 0);
    $display("mid-frame reset: restart at (%0d,%0d) fc=%0d", hpos_w[1], vpos_w[1], fc_w[1]);
    wait_main_fs(2, 6400, "post_rst_frame");
    chk("post_rst_fc", 1, 32'(fc_w[1]), 1);

    // Mid-line reset on inst0 at hpos 300
    wait_pos(0, 300, -1, 800, "reach_h300");
    rst_v[0] = 1'b0;
    tick();
    chk("full_rst_hpos", 0, 32'(hpos_w[0]), 799);
    chk("full_rst_vpos", 0, 32'(vpos_w[0]), 524);
    chk("full_rst_fc", 0, 32'(fc_w[0]), 0);
    rst_v[0] = 1'b1;
    tick();
    chk("full_rel_hpos", 0, 32'(hpos_w[0]), 0);
    chk("full_rel_vpos", 0, 32'(vpos_w[0]), 0);
    $display("mid-line reset: restart at (%0d,%0d)", hpos_w[0], vpos_w[0]);

    for (int i = 0; i < 6; i++) chk("tbl_vector_reached", 1, cell_hit[i], 1);
    chk("wrap_seen", 2, wrap_seen, 1);
    chk("line_sweep_done", 0, full_line_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
